sha2_w_sched: RTL and testbench

- Parametrised SHA-2 message-schedule generator that replaces the fixed SHA-256 W memory.
- Supports SHA-256 (32-bit words, 64 rounds) and SHA-512 (64-bit words, 80 rounds) from one RTL source, selected by parameter.
- Sits between the block input register and the round-function datapath; it supplies one W word per accepted round.
- Adds an explicit valid/next handshake with stall, a word index output, a completion pulse and restart on init at any time.

---
 rtl/sha2_pkg.sv | 37 +++
 rtl/sha2_sigma.sv | 31 +++
 rtl/sha2_w_sched.sv | 82 ++++++++
 tb/tb_sha2_w_sched.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha2_pkg.sv
// Shared SHA-2 constants: mode encoding, derived sizes, sigma amounts and schedule FSM states.
// Imported by the message-schedule generator and the sigma helper.
package sha2_pkg;

  localparam int unsigned MODE_SHA256 = 0;
  localparam int unsigned MODE_SHA512 = 1;

  // Sigma selectors: small sigmas feed the schedule, big Sigmas feed the round core.
  localparam int unsigned SIG_SMALL0 = 0;
  localparam int unsigned SIG_SMALL1 = 1;
  localparam int unsigned SIG_BIG0   = 2;
  localparam int unsigned SIG_BIG1   = 3;

  // [mode][selector][term]; the third term is a shift for small sigmas, a rotate for big ones.
  localparam int unsigned SIGMA_AMT [2][4][3] = '{
    '{'{7, 18, 3}, '{17, 19, 10}, '{2, 13, 22}, '{6, 11, 25}},
    '{'{1, 8, 7},  '{19, 61, 6},  '{28, 34, 39}, '{14, 18, 41}}
  };

  typedef enum logic [0:0] {StIdle, StRun} sched_state_e;

  function automatic int unsigned word_w(input int unsigned mode);
    return (mode == MODE_SHA512) ? 64 : 32;
  endfunction

  function automatic int unsigned rounds(input int unsigned mode);
    return (mode == MODE_SHA512) ? 80 : 64;
  endfunction

  function automatic int unsigned sigma_amt(input int unsigned mode, input int unsigned sel,
                                            input int unsigned k);
    int unsigned mi;
    mi = (mode == MODE_SHA512) ? 1 : 0;
    return SIGMA_AMT[mi][sel % 4][k % 3];
  endfunction

endpackage

// File: rtl/sha2_sigma.sv
// Combinational SHA-2 sigma function; SEL picks sig0/sig1 (schedule) or Sigma0/Sigma1 (rounds).
// Rotations are constant bit reorderings.
module sha2_sigma
  import sha2_pkg::*;
#(
  parameter int unsigned MODE = MODE_SHA256,
  parameter int unsigned SEL  = SIG_SMALL0,
  localparam int unsigned W   = word_w(MODE)
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  localparam int unsigned A0 = sigma_amt(MODE, SEL, 0);
  localparam int unsigned A1 = sigma_amt(MODE, SEL, 1);
  localparam int unsigned A2 = sigma_amt(MODE, SEL, 2);

  logic [W-1:0] r0, r1, t2;

  assign r0 = {x[A0-1:0], x[W-1:A0]};
  assign r1 = {x[A1-1:0], x[W-1:A1]};

  if (SEL < 2) begin : g_shr
    assign t2 = x >> A2;
  end else begin : g_rot
    assign t2 = {x[A2-1:0], x[W-1:A2]};
  end

  assign y = r0 ^ r1 ^ t2;

endmodule

// File: rtl/sha2_w_sched.sv
// SHA-2 message-schedule generator: 16-word sliding window emitting one W word per accepted next.
// init restarts from a fresh block at any time; done pulses once after the last word is taken.
module sha2_w_sched
  import sha2_pkg::*;
#(
  parameter int unsigned MODE    = MODE_SHA256,
  localparam int unsigned WORD_W = word_w(MODE),
  localparam int unsigned ROUNDS = rounds(MODE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [16*WORD_W-1:0]   block,
  input  logic                   init,
  input  logic                   next,
  output logic [WORD_W-1:0]      w,
  output logic [6:0]             w_idx,
  output logic                   w_valid,
  output logic                   done
);

  if (MODE != MODE_SHA256 && MODE != MODE_SHA512) begin : g_bad_mode
    $error("sha2_w_sched: MODE must be 0 (SHA-256) or 1 (SHA-512)");
  end

  localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);

  sched_state_e      state_q;
  logic [WORD_W-1:0] win_q [16];
  logic [6:0]        cnt_q;
  logic              done_q;
  logic [WORD_W-1:0] s0, s1, w_new;

  sha2_sigma #(
    .MODE (MODE),
    .SEL  (SIG_SMALL0)
  ) u_sig0 (
    .x (win_q[1]),
    .y (s0)
  );

  sha2_sigma #(
    .MODE (MODE),
    .SEL  (SIG_SMALL1)
  ) u_sig1 (
    .x (win_q[14]),
    .y (s1)
  );

  assign w_new = s1 + win_q[9] + s0 + win_q[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
      cnt_q   <= '0;
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (init) begin
        for (int i = 0; i < 16; i++) win_q[i] <= block[(15-i)*WORD_W +: WORD_W];
        cnt_q   <= '0;
        state_q <= StRun;
      end else if (state_q == StRun && next) begin
        if (cnt_q == LAST_IDX) begin
          // Window holds so nothing beyond the final round is ever computed onto w.
          state_q <= StIdle;
          done_q  <= 1'b1;
        end else begin
          for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
          win_q[15] <= w_new;
          cnt_q     <= cnt_q + 7'd1;
        end
      end
    end
  end

  assign w       = win_q[0];
  assign w_idx   = cnt_q;
  assign w_valid = (state_q == StRun);
  assign done    = done_q;

endmodule

// File: tb/tb_sha2_w_sched.sv
// Bench for sha2_w_sched: one SHA-256 and one SHA-512 instance checked every cycle against a
// textbook schedule recurrence, plus directed literal expectations.
module tb_sha2_w_sched;

  localparam int N_RAND = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset0, init0, next0;
  logic [511:0] blk0;
  logic [31:0]  w0;
  logic [6:0]   idx0;
  logic         v0, d0;

  logic          reset1, init1, next1;
  logic [1023:0] blk1;
  logic [63:0]   w1;
  logic [6:0]    idx1;
  logic          v1, d1;

  sha2_w_sched #(.MODE(0)) u_dut0 (
    .clk     (clk),
    .reset   (reset0),
    .block   (blk0),
    .init    (init0),
    .next    (next0),
    .w       (w0),
    .w_idx   (idx0),
    .w_valid (v0),
    .done    (d0)
  );

  sha2_w_sched #(.MODE(1)) u_dut1 (
    .clk     (clk),
    .reset   (reset1),
    .block   (blk1),
    .init    (init1),
    .next    (next1),
    .w       (w1),
    .w_idx   (idx1),
    .w_valid (v1),
    .done    (d1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- software model ----------------
  logic [63:0] sched [2][80];
  bit          mv    [2];
  int          midx  [2];
  bit          mdone [2];
  bit          mpost [2];
  int          dut_dones [2];
  bit          live = 1'b0;

  function automatic logic [63:0] msk(input int m);
    return (m != 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int m);
    int ww;
    ww = (m != 0) ? 64 : 32;
    return ((x >> n) | (x << (ww - n))) & msk(m);
  endfunction

  function automatic logic [63:0] sig0(input logic [63:0] x, input int m);
    if (m != 0) return rotr(x, 1, m) ^ rotr(x, 8, m) ^ (x >> 7);
    return rotr(x, 7, m) ^ rotr(x, 18, m) ^ (x >> 3);
  endfunction

  function automatic logic [63:0] sig1(input logic [63:0] x, input int m);
    if (m != 0) return rotr(x, 19, m) ^ rotr(x, 61, m) ^ (x >> 6);
    return rotr(x, 17, m) ^ rotr(x, 19, m) ^ (x >> 10);
  endfunction

  function automatic int nrounds(input int m);
    return (m != 0) ? 80 : 64;
  endfunction

  task automatic gen_sched(input int m, input logic [1023:0] blk);
    for (int i = 0; i < 16; i++)
      sched[m][i] = (m != 0) ? blk[(15-i)*64 +: 64] : {32'b0, blk[(15-i)*32 +: 32]};
    for (int i = 16; i < nrounds(m); i++)
      sched[m][i] = (sig1(sched[m][i-2], m) + sched[m][i-7] + sig0(sched[m][i-15], m)
                     + sched[m][i-16]) & msk(m);
  endtask

  task automatic model_step(input int m, input bit r, input bit ini, input bit nxt,
                            input logic [1023:0] blk);
    if (r) begin
      mv[m] = 1'b0; midx[m] = 0; mdone[m] = 1'b0; mpost[m] = 1'b1;
    end else begin
      mdone[m] = 1'b0;
      if (ini) begin
        gen_sched(m, blk);
        midx[m] = 0; mv[m] = 1'b1; mpost[m] = 1'b0;
      end else if (mv[m] && nxt) begin
        if (midx[m] == nrounds(m) - 1) begin
          mv[m] = 1'b0; mdone[m] = 1'b1;
        end else begin
          midx[m]++;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, reset0, init0, next0, {512'b0, blk0});
    model_step(1, reset1, init1, next1, blk1);
    live = 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  logic [63:0] cw;
  logic [6:0]  ci;
  logic        cv, cd;

  always @(negedge clk) begin
    if (live) begin
      for (int m = 0; m < 2; m++) begin
        cw = (m != 0) ? w1 : {32'b0, w0};
        ci = (m != 0) ? idx1 : idx0;
        cv = (m != 0) ? v1 : v0;
        cd = (m != 0) ? d1 : d0;
        chk($sformatf("m%0d_w_valid", m), {63'b0, cv}, {63'b0, mv[m]});
        chk($sformatf("m%0d_done", m), {63'b0, cd}, {63'b0, mdone[m]});
        if (cd) dut_dones[m]++;
        if (mv[m]) begin
          chk($sformatf("m%0d_w_idx", m), {57'b0, ci}, 64'(midx[m]));
          chk($sformatf("m%0d_w@%0d", m, midx[m]), cw, sched[m][midx[m]]);
        end else if (mpost[m]) begin
          chk($sformatf("m%0d_w_after_reset", m), cw, 64'h0);
          chk($sformatf("m%0d_idx_after_reset", m), {57'b0, ci}, 64'h0);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] cur_w(input int m);
    return (m != 0) ? w1 : {32'b0, w0};
  endfunction

  function automatic int cur_idx(input int m);
    return (m != 0) ? int'(idx1) : int'(idx0);
  endfunction

  function automatic bit cur_valid(input int m);
    return (m != 0) ? v1 : v0;
  endfunction

  function automatic bit cur_done(input int m);
    return (m != 0) ? d1 : d0;
  endfunction

  task automatic drive(input int m, input bit r, input bit ini, input bit nxt);
    if (m != 0) begin reset1 = r; init1 = ini; next1 = nxt; end
    else begin reset0 = r; init0 = ini; next0 = nxt; end
  endtask

  task automatic set_blk(input int m, input logic [1023:0] b);
    if (m != 0) blk1 = b;
    else blk0 = b[511:0];
  endtask

  task automatic rand_blk(output logic [1023:0] b);
    for (int k = 0; k < 32; k++) b[k*32 +: 32] = $urandom();
  endtask

  task automatic wait_idx(input int m, input int t);
    int k;
    k = 0;
    while (cur_idx(m) != t && k < 400) begin step(); k++; end
    chk($sformatf("m%0d_reach_idx_%0d", m, t), 64'(cur_idx(m)), 64'(t));
  endtask

  task automatic wait_done(input int m, input bit rnd);
    logic [1023:0] b;
    int k;
    k = 0;
    while (!cur_done(m) && k < 3000) begin
      if (rnd) begin
        drive(m, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        rand_blk(b);
        set_blk(m, b);
      end
      step();
      k++;
    end
    chk($sformatf("m%0d_done_seen", m), {63'b0, cur_done(m)}, 64'h1);
    chk($sformatf("m%0d_idx_at_done", m), 64'(cur_idx(m)), 64'(nrounds(m) - 1));
    drive(m, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start(input int m, input logic [1023:0] b);
    set_blk(m, b);
    drive(m, 1'b0, 1'b1, 1'b1);
    step();
    drive(m, 1'b0, 1'b0, 1'b1);
  endtask

  logic [1023:0] abc0, abc1, rb;

  initial begin
    abc0 = '0;
    abc0[511:480] = 32'h6162_6380;
    abc0[31:0]    = 32'h0000_0018;
    abc1 = '0;
    abc1[1023:960] = 64'h6162_6380_0000_0000;
    abc1[63:0]     = 64'h18;
    blk0 = '0;
    blk1 = '0;
    drive(0, 1'b1, 1'b0, 1'b0);
    drive(1, 1'b1, 1'b0, 1'b0);
    repeat (2) step();
    chk("m0_rst_valid", {63'b0, v0}, 64'h0);
    chk("m0_rst_w", {32'b0, w0}, 64'h0);
    chk("m0_rst_idx", {57'b0, idx0}, 64'h0);
    chk("m0_rst_done", {63'b0, d0}, 64'h0);
    chk("m1_rst_valid", {63'b0, v1}, 64'h0);
    chk("m1_rst_w", w1, 64'h0);
    chk("m1_rst_idx", {57'b0, idx1}, 64'h0);
    chk("m1_rst_done", {63'b0, d1}, 64'h0);
    // next while idle must be ignored
    drive(0, 1'b0, 1'b0, 1'b1);
    drive(1, 1'b0, 1'b0, 1'b1);
    repeat (3) step();
    chk("m0_idle_next_valid", {63'b0, v0}, 64'h0);
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);

    // SHA-256 "abc"
    start(0, abc0);
    chk("m0_abc_w0", cur_w(0), 64'h6162_6380);
    chk("m0_abc_valid", {63'b0, cur_valid(0)}, 64'h1);
    chk("model_m0_w16", sched[0][16], 64'h6162_6380);
    chk("model_m0_w17", sched[0][17], 64'h000F_0000);
    chk("model_m0_w18", sched[0][18], 64'h7DA8_6405);
    chk("model_m0_w19", sched[0][19], 64'h6000_03C6);
    wait_idx(0, 15); chk("m0_abc_w15", cur_w(0), 64'h18);
    wait_idx(0, 16); chk("m0_abc_w16", cur_w(0), 64'h6162_6380);
    wait_idx(0, 17); chk("m0_abc_w17", cur_w(0), 64'h000F_0000);
    wait_idx(0, 18); chk("m0_abc_w18", cur_w(0), 64'h7DA8_6405);
    wait_idx(0, 19); chk("m0_abc_w19", cur_w(0), 64'h6000_03C6);
    wait_done(0, 1'b0);
    step();
    chk("m0_done_one_cycle", {63'b0, cur_done(0)}, 64'h0);

    // stall at index 20
    start(0, abc0);
    wait_idx(0, 20);
    drive(0, 1'b0, 1'b0, 1'b0);
    repeat (5) begin
      step();
      chk("m0_stall_w", cur_w(0), sched[0][20]);
      chk("m0_stall_idx", 64'(cur_idx(0)), 64'd20);
    end
    drive(0, 1'b0, 1'b0, 1'b1);
    wait_done(0, 1'b0);

    // restart at index 30 with next high in the same cycle
    rand_blk(rb);
    start(0, rb);
    wait_idx(0, 30);
    rand_blk(rb);
    rb[511:480] = 32'hDEAD_BEEF;
    set_blk(0, rb);
    drive(0, 1'b0, 1'b1, 1'b1);
    step();
    drive(0, 1'b0, 1'b0, 1'b1);
    chk("m0_restart_idx", 64'(cur_idx(0)), 64'd0);
    chk("m0_restart_w", cur_w(0), 64'hDEAD_BEEF);
    chk("m0_restart_nodone", {63'b0, cur_done(0)}, 64'h0);
    wait_done(0, 1'b0);

    // reset mid-run at index 40
    start(0, abc0);
    wait_idx(0, 40);
    drive(0, 1'b1, 1'b0, 1'b1);
    step();
    drive(0, 1'b0, 1'b0, 1'b0);
    chk("m0_midrst_valid", {63'b0, cur_valid(0)}, 64'h0);
    chk("m0_midrst_w", cur_w(0), 64'h0);
    chk("m0_midrst_idx", 64'(cur_idx(0)), 64'h0);
    chk("m0_midrst_done", {63'b0, cur_done(0)}, 64'h0);
    repeat (4) begin
      drive(0, 1'b0, 1'b0, 1'b1); step();
      drive(0, 1'b0, 1'b0, 1'b0); step();
    end
    chk("m0_post_rst_idle", {63'b0, cur_valid(0)}, 64'h0);

    // SHA-512 "abc"
    start(1, abc1);
    chk("m1_abc_w0", cur_w(1), 64'h6162_6380_0000_0000);
    chk("model_m1_w16", sched[1][16], 64'h6162_6380_0000_0000);
    chk("model_m1_w17", sched[1][17], 64'h0003_0000_0000_00C0);
    wait_idx(1, 16); chk("m1_abc_w16", cur_w(1), 64'h6162_6380_0000_0000);
    wait_idx(1, 17); chk("m1_abc_w17", cur_w(1), 64'h0003_0000_0000_00C0);
    wait_done(1, 1'b0);

    // random blocks with random next gaps and a wiggling block input
    for (int m = 0; m < 2; m++) begin
      for (int r = 0; r < N_RAND; r++) begin
        rand_blk(rb);
        start(m, rb);
        wait_done(m, 1'b1);
      end
    end

    step();
    step();
    chk("m0_done_count", 64'(dut_dones[0]), 64'(3 + N_RAND));
    chk("m1_done_count", 64'(dut_dones[1]), 64'(1 + N_RAND));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
